reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
Shares one register access port (wr/rd address, enable, data, strobe, ack) between two requesters, e.g. the AXI4-Lite interface block and a local hardware sequencer, in front of a peripheral's register file.
- Round-robin arbitration.
- One outstanding transaction at a time.
- Per-transaction ack timeout: a missing slave ack never stalls the bus.

Parameters:
ADDR_BITS, 4, register address width in bits.
TIMEOUT, 16, cycles allowed in WAIT before an error completion; minimum 2.
ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out read.

Ports:
s_axi_aclk  in  1  system clock; all logic on its rising edge.
s_axi_aresetn  in  1  asynchronous, active-low reset.
m_wr_addr  in  2*ADDR_BITS  requester write addresses; slot i = bits [i*ADDR_BITS +: ADDR_BITS].
m_wr_en  in  2  write request level, held with addr/data/strb stable until the matching m_wr_ack.
m_wr_data  in  64  write data, 32 bits per slot.
m_wr_strb  in  8  byte enables, 4 bits per slot.
m_wr_ack  out  2  one-cycle write completion pulse per requester.
m_rd_addr  in  2*ADDR_BITS  requester read addresses.
m_rd_en  in  2  read request level, held until the matching m_rd_ack.
m_rd_data  out  32  read data; valid while any m_rd_ack bit is high.
m_rd_ack  out  2  one-cycle read completion pulse per requester.
m_err  out  2  high together with the ack bit when the completion timed out.
s_wr_addr  out  ADDR_BITS  slave write address.
s_wr_en  out  1  slave write enable; one-cycle pulse.
s_wr_data  out  32  slave write data.
s_wr_strb  out  4  slave byte enables.
s_wr_ack  in  1  slave write acknowledge.
s_rd_addr  out  ADDR_BITS  slave read address.
s_rd_en  out  1  slave read enable; one-cycle pulse.
s_rd_data  in  32  slave read data, sampled in the cycle s_rd_ack is high.
s_rd_ack  in  1  slave read acknowledge.
busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (async, s_axi_aresetn=0):
  - All outputs 0; state IDLE.
  - last_grant=1, so requester 0 wins first.
  - Timeout counter 0.
  - Reset mid-transaction aborts it with no ack; the requester still holds en and is re-arbitrated after reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Pending set: p[i] = m_wr_en[i] | m_rd_en[i].
  - If p nonzero, winner = the requester other than last_grant if it is pending, else the pending one.
  - Within one requester, write beats read when both are pending.
  - Latch winner index, operation type, addr, data, strb into registers. Go to ISSUE.
- ISSUE:
  - Drive s_wr_en or s_rd_en high for exactly this cycle. s_*_addr/data/strb come from the latch registers and are stable ISSUE through RESP.
  - Ack of the active type seen this cycle: capture s_rd_data for reads, go to RESP.
  - Otherwise go to WAIT with counter=0.
- WAIT:
  - Enables low. Counter increments each cycle.
  - Ack of the active type: capture data, go to RESP, err=0.
  - Else if counter==TIMEOUT-1: go to RESP, err=1, read data=ERR_DATA.
  - Ack has priority over timeout in the same cycle.
  - Acks of the inactive type and acks in IDLE/RESP are ignored.
- RESP:
  - Pulse m_wr_ack[w] or m_rd_ack[w] plus m_err[w] for one cycle.
  - m_rd_data holds the captured value while the ack is high; 0 otherwise.
  - last_grant=w. Go to IDLE.
- Latency:
  - m_*_en asserted in cycle N while IDLE: s_*_en in N+1.
  - Zero-wait slave ack in N+1 gives m_*_ack in N+2.
  - Each WAIT cycle adds one.
  - Back-to-back transactions are spaced 3 cycles minimum.
- Requesters drop en in the cycle after their ack. Arbitration in the following IDLE therefore never re-grants a completed request.
- A requester whose en drops before its ack: the transaction still completes and the ack is still pulsed.
- No combinational path from m_* inputs to s_* outputs. All s_* and m_* outputs are registered.

Decomposition:
- Shared package reg_bus_pkg holds:
  - the FSM state encoding;
  - the operation-type constants OP_WR/OP_RD;
  - the data width 32 and strobe width 4.
- One sub-module, rr_arbiter2: a two-input round-robin grant with last_grant register and update strobe. Everything else lives in reg_bus_arbiter.

Test Plan:
- Single write: m_wr_en[0]=1, addr 4'h4, data 32'h0000_00A5, strb 4'hF, slave acks in ISSUE -> s_wr_en pulse with those values; m_wr_ack[0] 2 cycles after request; m_err=0.
- Contention: m_rd_en=2'b11 asserted in the same cycle after reset -> requester 0 served first, then requester 1; slave returns 32'h1234_5678 then 32'h0000_0042 -> m_rd_data matches each ack.
- Round-robin fairness: both requesters issue continuous writes for 10 transactions -> grants alternate 0,1,0,1,...; neither requester gets two consecutive grants.
- Timeout: read with the slave never acking, TIMEOUT=16 -> m_rd_ack and m_err high after 16 WAIT cycles; m_rd_data=32'hDEAD_BEEF.
- Wrong-type and late acks: write outstanding, s_rd_ack pulsed, then s_wr_ack after 3 cycles -> read ack ignored; write completes with err=0.
- Async reset in WAIT: assert s_axi_aresetn=0 mid-transaction -> all outputs 0 immediately; after release the held request re-issues and completes normally.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the two-requester register bus arbiter.
package reg_bus_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; the requester that did not win last time has priority.
module rr_arbiter2 (
  input  logic       clk_sys,
  input  logic       rst_b,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_idx,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    last_grant_d = update ? update_idx : last_grant_q;
    gnt_valid    = |req;
    gnt_idx      = req[~last_grant_q] ? ~last_grant_q : last_grant_q;
  end

  // Reset value 1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register-file access port between two requesters, one transaction
// in flight at a time, with a per-transaction ack timeout.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch winner's op/addr/data/strb
// ISSUE | one-cycle slave enable pulse; zero-wait ack accepted here
// WAIT  | count cycles until matching ack or timeout
// RESP  | one-cycle ack (and err) pulse to the winner, update round-robin
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int          ADDR_BITS = 4,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic [2*ADDR_BITS-1:0] m_wr_addr,
  input  logic [1:0]             m_wr_en,
  input  logic [2*DATA_W-1:0]    m_wr_data,
  input  logic [2*STRB_W-1:0]    m_wr_strb,
  output logic [1:0]             m_wr_ack,
  input  logic [2*ADDR_BITS-1:0] m_rd_addr,
  input  logic [1:0]             m_rd_en,
  output logic [DATA_W-1:0]      m_rd_data,
  output logic [1:0]             m_rd_ack,
  output logic [1:0]             m_err,
  output logic [ADDR_BITS-1:0]   s_wr_addr,
  output logic                   s_wr_en,
  output logic [DATA_W-1:0]      s_wr_data,
  output logic [STRB_W-1:0]      s_wr_strb,
  input  logic                   s_wr_ack,
  output logic [ADDR_BITS-1:0]   s_rd_addr,
  output logic                   s_rd_en,
  input  logic [DATA_W-1:0]      s_rd_data,
  input  logic                   s_rd_ack,
  output logic                   busy
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic                 win_q, win_d;
  logic                 op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] s_wr_addr_q, s_wr_addr_d;
  logic [ADDR_BITS-1:0] s_rd_addr_q, s_rd_addr_d;
  logic [DATA_W-1:0]    s_wr_data_q, s_wr_data_d;
  logic [STRB_W-1:0]    s_wr_strb_q, s_wr_strb_d;
  logic                 s_wr_en_q, s_wr_en_d;
  logic                 s_rd_en_q, s_rd_en_d;
  logic [1:0]           m_wr_ack_q, m_wr_ack_d;
  logic [1:0]           m_rd_ack_q, m_rd_ack_d;
  logic [1:0]           m_err_q, m_err_d;
  logic [DATA_W-1:0]    m_rd_data_q, m_rd_data_d;
  logic                 busy_q, busy_d;

  logic gnt_valid, gnt_idx, arb_update;
  logic act_ack, done, timed_out;

  rr_arbiter2 u_rr (
    .clk_sys    (s_axi_aclk),
    .rst_b      (s_axi_aresetn),
    .req        (m_wr_en | m_rd_en),
    .update     (arb_update),
    .update_idx (win_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    s_wr_addr_d = s_wr_addr_q;
    s_rd_addr_d = s_rd_addr_q;
    s_wr_data_d = s_wr_data_q;
    s_wr_strb_d = s_wr_strb_q;
    s_wr_en_d   = 1'b0;
    s_rd_en_d   = 1'b0;
    m_wr_ack_d  = 2'b00;
    m_rd_ack_d  = 2'b00;
    m_err_d     = 2'b00;
    m_rd_data_d = '0;
    arb_update  = 1'b0;
    done        = 1'b0;
    timed_out   = 1'b0;
    act_ack     = (op_q == OP_WR) ? s_wr_ack : s_rd_ack;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          win_d   = gnt_idx;
          state_d = ST_ISSUE;
          // Write wins over read within the same requester.
          if (m_wr_en[gnt_idx]) begin
            op_d        = OP_WR;
            s_wr_en_d   = 1'b1;
            s_wr_addr_d = gnt_idx ? m_wr_addr[2*ADDR_BITS-1:ADDR_BITS] : m_wr_addr[ADDR_BITS-1:0];
            s_wr_data_d = gnt_idx ? m_wr_data[2*DATA_W-1:DATA_W] : m_wr_data[DATA_W-1:0];
            s_wr_strb_d = gnt_idx ? m_wr_strb[2*STRB_W-1:STRB_W] : m_wr_strb[STRB_W-1:0];
          end else begin
            op_d        = OP_RD;
            s_rd_en_d   = 1'b1;
            s_rd_addr_d = gnt_idx ? m_rd_addr[2*ADDR_BITS-1:ADDR_BITS] : m_rd_addr[ADDR_BITS-1:0];
          end
        end
      end
      ST_ISSUE: begin
        if (act_ack) begin
          done = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (act_ack) begin
          done = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        arb_update = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      state_d        = ST_RESP;
      m_err_d[win_q] = timed_out;
      if (op_q == OP_WR) begin
        m_wr_ack_d[win_q] = 1'b1;
      end else begin
        m_rd_ack_d[win_q] = 1'b1;
        m_rd_data_d       = timed_out ? ERR_DATA : s_rd_data;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= ST_IDLE;
      win_q       <= 1'b0;
      op_q        <= OP_WR;
      cnt_q       <= '0;
      s_wr_addr_q <= '0;
      s_rd_addr_q <= '0;
      s_wr_data_q <= '0;
      s_wr_strb_q <= '0;
      s_wr_en_q   <= 1'b0;
      s_rd_en_q   <= 1'b0;
      m_wr_ack_q  <= 2'b00;
      m_rd_ack_q  <= 2'b00;
      m_err_q     <= 2'b00;
      m_rd_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      s_wr_addr_q <= s_wr_addr_d;
      s_rd_addr_q <= s_rd_addr_d;
      s_wr_data_q <= s_wr_data_d;
      s_wr_strb_q <= s_wr_strb_d;
      s_wr_en_q   <= s_wr_en_d;
      s_rd_en_q   <= s_rd_en_d;
      m_wr_ack_q  <= m_wr_ack_d;
      m_rd_ack_q  <= m_rd_ack_d;
      m_err_q     <= m_err_d;
      m_rd_data_q <= m_rd_data_d;
      busy_q      <= busy_d;
    end
  end

  assign s_wr_addr = s_wr_addr_q;
  assign s_rd_addr = s_rd_addr_q;
  assign s_wr_data = s_wr_data_q;
  assign s_wr_strb = s_wr_strb_q;
  assign s_wr_en   = s_wr_en_q;
  assign s_rd_en   = s_rd_en_q;
  assign m_wr_ack  = m_wr_ack_q;
  assign m_rd_ack  = m_rd_ack_q;
  assign m_err     = m_err_q;
  assign m_rd_data = m_rd_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: tests push expected slave issues and
// requester completions; a negedge monitor pops and compares.
module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        s_axi_aresetn;
  logic [7:0]  m_wr_addr, m_rd_addr;
  logic [1:0]  m_wr_en, m_rd_en;
  logic [63:0] m_wr_data;
  logic [7:0]  m_wr_strb;
  logic [1:0]  m_wr_ack, m_rd_ack, m_err;
  logic [31:0] m_rd_data;
  logic [3:0]  s_wr_addr, s_rd_addr, s_wr_strb;
  logic        s_wr_en, s_rd_en, s_wr_ack, s_rd_ack, busy;
  logic [31:0] s_wr_data, s_rd_data;

  logic        wr_en_r[2], rd_en_r[2];
  logic [3:0]  wr_addr_r[2], rd_addr_r[2], wr_strb_r[2];
  logic [31:0] wr_data_r[2];

  assign m_wr_en   = {wr_en_r[1], wr_en_r[0]};
  assign m_rd_en   = {rd_en_r[1], rd_en_r[0]};
  assign m_wr_addr = {wr_addr_r[1], wr_addr_r[0]};
  assign m_rd_addr = {rd_addr_r[1], rd_addr_r[0]};
  assign m_wr_data = {wr_data_r[1], wr_data_r[0]};
  assign m_wr_strb = {wr_strb_r[1], wr_strb_r[0]};

  reg_bus_arbiter dut (
    .s_axi_aclk(clk), .s_axi_aresetn(s_axi_aresetn),
    .m_wr_addr(m_wr_addr), .m_wr_en(m_wr_en), .m_wr_data(m_wr_data), .m_wr_strb(m_wr_strb),
    .m_wr_ack(m_wr_ack), .m_rd_addr(m_rd_addr), .m_rd_en(m_rd_en), .m_rd_data(m_rd_data),
    .m_rd_ack(m_rd_ack), .m_err(m_err), .s_wr_addr(s_wr_addr), .s_wr_en(s_wr_en),
    .s_wr_data(s_wr_data), .s_wr_strb(s_wr_strb), .s_wr_ack(s_wr_ack), .s_rd_addr(s_rd_addr),
    .s_rd_en(s_rd_en), .s_rd_data(s_rd_data), .s_rd_ack(s_rd_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          cyc;
  } iss_t;

  typedef struct packed {
    logic        rd;
    logic        idx;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } cmp_t;

  iss_t        iss_q[$];
  cmp_t        cmp_q[$];
  logic [31:0] slv_rd_q[$];
  bit          slv_auto = 1'b0;

  function automatic void push_iss(bit wr, logic [3:0] addr, logic [31:0] data, logic [3:0] strb, int c);
    iss_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.strb = strb; e.cyc = c;
    iss_q.push_back(e);
  endfunction

  function automatic void push_cmp(bit rd, bit idx, logic [31:0] data, bit err, int c);
    cmp_t e;
    e.rd = rd; e.idx = idx; e.data = data; e.err = err; e.cyc = c;
    cmp_q.push_back(e);
  endfunction

  // Zero-wait slave: acks the active type in the issue cycle.
  initial begin
    s_wr_ack = 1'b0; s_rd_ack = 1'b0; s_rd_data = '0;
    forever begin
      @(negedge clk);
      if (slv_auto) begin
        s_wr_ack = 1'b0; s_rd_ack = 1'b0;
        if (s_wr_en) s_wr_ack = 1'b1;
        else if (s_rd_en) begin
          s_rd_ack  = 1'b1;
          s_rd_data = (slv_rd_q.size() != 0) ? slv_rd_q.pop_front() : 32'h0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (s_wr_en || s_rd_en) begin
      iss_t e;
      checks++;
      if (iss_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got wr_en=%0b rd_en=%0b at cyc %0d, required none", s_wr_en, s_rd_en, cyc);
      end else begin
        e = iss_q.pop_front();
        if (s_wr_en !== e.wr || s_rd_en !== !e.wr || cyc != e.cyc ||
            (e.wr && (s_wr_addr !== e.addr || s_wr_data !== e.data || s_wr_strb !== e.strb)) ||
            (!e.wr && s_rd_addr !== e.addr)) begin
          errors++;
          $display("FAIL issue: got wr=%0b rd=%0b waddr=%h wdata=%h strb=%h raddr=%h cyc=%0d, required wr=%0b addr=%h data=%h strb=%h cyc=%0d",
                   s_wr_en, s_rd_en, s_wr_addr, s_wr_data, s_wr_strb, s_rd_addr, cyc,
                   e.wr, e.addr, e.data, e.strb, e.cyc);
        end
      end
    end
    if (m_wr_ack != 2'b00 || m_rd_ack != 2'b00) begin
      cmp_t e;
      logic [1:0]  oh;
      logic [31:0] exp_data;
      checks++;
      if (cmp_q.size() == 0) begin
        errors++;
        $display("FAIL completion_unexpected: got wr_ack=%b rd_ack=%b at cyc %0d, required none", m_wr_ack, m_rd_ack, cyc);
      end else begin
        e = cmp_q.pop_front();
        oh = e.idx ? 2'b10 : 2'b01;
        exp_data = e.rd ? e.data : 32'h0;
        if (m_wr_ack !== (e.rd ? 2'b00 : oh) || m_rd_ack !== (e.rd ? oh : 2'b00) ||
            m_err !== (e.err ? oh : 2'b00) || m_rd_data !== exp_data || cyc != e.cyc) begin
          errors++;
          $display("FAIL completion: got wr_ack=%b rd_ack=%b err=%b data=%h cyc=%0d, required rd=%0b idx=%0d err=%0b data=%h cyc=%0d",
                   m_wr_ack, m_rd_ack, m_err, m_rd_data, cyc, e.rd, e.idx, e.err, exp_data, e.cyc);
        end
      end
    end else begin
      checks++;
      if (m_rd_data !== 32'h0 || m_err !== 2'b00) begin
        errors++;
        $display("FAIL idle_outputs: got rd_data=%h err=%b at cyc %0d, required 0", m_rd_data, m_err, cyc);
      end
    end
  end

  task automatic chk_all_zero(input string name);
    logic [94:0] v;
    v = {m_wr_ack, m_rd_ack, m_err, m_rd_data, s_wr_addr, s_wr_en, s_wr_data, s_wr_strb, s_rd_addr, s_rd_en, busy};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: got outputs %h, required all zero", name, v);
    end
  endtask

  task automatic req_txn(input int idx, input bit rd, input logic [3:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    bit got = 1'b0;
    if (rd) begin
      rd_addr_r[idx] = addr; rd_en_r[idx] = 1'b1;
    end else begin
      wr_addr_r[idx] = addr; wr_data_r[idx] = data; wr_strb_r[idx] = strb; wr_en_r[idx] = 1'b1;
    end
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (rd ? m_rd_ack[idx] : m_wr_ack[idx]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_wait: req%0d rd=%0b got no ack, required ack within 100 cycles", idx, rd);
    end
    if (rd) rd_en_r[idx] = 1'b0;
    else    wr_en_r[idx] = 1'b0;
  endtask

  task automatic do_reset();
    s_axi_aresetn = 1'b0;
    @(negedge clk);
    s_axi_aresetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    s_axi_aresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_en_r[i] = 1'b0; rd_en_r[i] = 1'b0;
      wr_addr_r[i] = '0; rd_addr_r[i] = '0; wr_strb_r[i] = '0; wr_data_r[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk_all_zero("reset_state");
    s_axi_aresetn = 1'b1;
    slv_auto = 1'b1;
    @(negedge clk);

    // Single zero-wait write
    c = cyc;
    push_iss(1'b1, 4'h4, 32'h0000_00A5, 4'hF, c + 1);
    push_cmp(1'b0, 1'b0, 32'h0, 1'b0, c + 2);
    req_txn(0, 1'b0, 4'h4, 32'h0000_00A5, 4'hF);
    @(negedge clk);

    // Simultaneous reads after reset: requester 0 first
    do_reset();
    c = cyc;
    slv_rd_q.push_back(32'h1234_5678);
    slv_rd_q.push_back(32'h0000_0042);
    push_iss(1'b0, 4'h1, 32'h0, 4'h0, c + 1);
    push_cmp(1'b1, 1'b0, 32'h1234_5678, 1'b0, c + 2);
    push_iss(1'b0, 4'h2, 32'h0, 4'h0, c + 4);
    push_cmp(1'b1, 1'b1, 32'h0000_0042, 1'b0, c + 5);
    fork
      req_txn(0, 1'b1, 4'h1, 32'h0, 4'h0);
      req_txn(1, 1'b1, 4'h2, 32'h0, 4'h0);
    join
    @(negedge clk);

    // Wrong-type ack ignored, late write ack completes without error
    slv_auto = 1'b0;
    c = cyc;
    push_iss(1'b1, 4'hC, 32'h5555_AAAA, 4'h3, c + 1);
    push_cmp(1'b0, 1'b1, 32'h0, 1'b0, c + 6);
    fork
      req_txn(1, 1'b0, 4'hC, 32'h5555_AAAA, 4'h3);
      begin
        repeat (2) @(negedge clk);
        s_rd_ack = 1'b1; s_rd_data = 32'h1111_1111;
        @(negedge clk);
        s_rd_ack = 1'b0; s_rd_data = 32'h0;
        repeat (2) @(negedge clk);
        s_wr_ack = 1'b1;
        @(negedge clk);
        s_wr_ack = 1'b0;
      end
    join
    @(negedge clk);

    // Read timeout: slave never acks
    c = cyc;
    push_iss(1'b0, 4'h7, 32'h0, 4'h0, c + 1);
    push_cmp(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, c + 18);
    req_txn(0, 1'b1, 4'h7, 32'h0, 4'h0);
    @(negedge clk);

    // Async reset during WAIT; held request re-issues afterwards
    c = cyc;
    push_iss(1'b0, 4'h9, 32'h0, 4'h0, c + 1);
    fork
      req_txn(0, 1'b1, 4'h9, 32'h0, 4'h0);
      begin
        int r;
        repeat (5) @(negedge clk);
        #2 s_axi_aresetn = 1'b0;
        #1 chk_all_zero("reset_in_wait");
        @(negedge clk);
        r = cyc;
        slv_auto = 1'b1;
        slv_rd_q.push_back(32'hCAFE_F00D);
        push_iss(1'b0, 4'h9, 32'h0, 4'h0, r + 1);
        push_cmp(1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, r + 2);
        s_axi_aresetn = 1'b1;
      end
    join
    @(negedge clk);

    // Fairness: continuous writes from both requesters alternate 0,1,0,1,...
    do_reset();
    c = cyc;
    for (int k = 0; k < 10; k++) begin
      int i, j;
      i = k % 2; j = k / 2;
      push_iss(1'b1, 4'(i * 8 + j), 32'hF000_0000 | 32'(i << 8) | 32'(j), 4'(j + 1), c + 1 + 3 * k);
      push_cmp(1'b0, i[0], 32'h0, 1'b0, c + 2 + 3 * k);
    end
    fork
      begin
        for (int j = 0; j < 5; j++) begin
          req_txn(0, 1'b0, 4'(j), 32'hF000_0000 | 32'(j), 4'(j + 1));
          @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 5; j++) begin
          req_txn(1, 1'b0, 4'(8 + j), 32'hF000_0100 | 32'(j), 4'(j + 1));
          @(negedge clk);
        end
      end
    join

    repeat (3) @(negedge clk);
    checks++;
    if (iss_q.size() != 0 || cmp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d issues and %0d completions left, required 0", iss_q.size(), cmp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
